// File: rtl/adder_tree_pipe_if.sv
// Operand/sum bus for adder_tree_pipe.
// The frame accumulator signals exist only when ADDER_TREE_ACC_EN is defined.
interface adder_tree_pipe_if #(
    parameter int NUM_IN   = 8,
    parameter int IN_WIDTH = 128
`ifdef ADDER_TREE_ACC_EN
    ,
    parameter int ACC_EXTRA = 16
`endif
);
    localparam int LEVELS    = $clog2(NUM_IN);
    localparam int SUM_WIDTH = IN_WIDTH + LEVELS;

    logic                       in_valid;
    logic [NUM_IN*IN_WIDTH-1:0] in_data;
    logic                       out_valid;
    logic [SUM_WIDTH-1:0]       out_sum;

`ifdef ADDER_TREE_ACC_EN
    localparam int ACC_WIDTH = SUM_WIDTH + ACC_EXTRA;

    logic                 in_last;
    logic                 acc_valid;
    logic [ACC_WIDTH-1:0] acc_sum;

    modport master (
        output in_valid, in_data, in_last,
        input  out_valid, out_sum, acc_valid, acc_sum
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output out_valid, out_sum, acc_valid, acc_sum
    );
`else
    modport master (
        output in_valid, in_data,
        input  out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_sum
    );
`endif
endinterface

// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree: sums NUM_IN operands of IN_WIDTH bits per beat.
// Each level widens its result by one bit, so the sum is always exact.
// A register follows every REG_STRIDE-th level and always the last one.
// Latency = 1 + ceil(LEVELS / REG_STRIDE) cycles.
// Defining ADDER_TREE_ACC_EN adds a per-frame accumulator driven by in_last.
module adder_tree_pipe #(
    parameter int NUM_IN     = 8,
    parameter int IN_WIDTH   = 128,
    parameter int REG_STRIDE = 1,
    parameter int SIGNED     = 0
`ifdef ADDER_TREE_ACC_EN
    ,
    parameter int ACC_EXTRA  = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    adder_tree_pipe_if.slave   bus
);
    localparam int LEVELS    = $clog2(NUM_IN);
    localparam int SUM_WIDTH = IN_WIDTH + LEVELS;

    logic [IN_WIDTH-1:0] s0_data [NUM_IN];
    logic                s0_valid;
`ifdef ADDER_TREE_ACC_EN
    logic                s0_last;
`endif

    // Stage 0: capture the operands of each valid beat; data holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                s0_data[i] <= '0;
            end
        end else begin
            s0_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    s0_data[i] <= bus.in_data[i*IN_WIDTH +: IN_WIDTH];
                end
            end
        end
    end

`ifdef ADDER_TREE_ACC_EN
    // Stage 0 frame marker; only meaningful alongside a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_last <= 1'b0;
        end else begin
            s0_last <= bus.in_valid & bus.in_last;
        end
    end
`endif

    for (genvar k = 1; k <= LEVELS; k++) begin : lvl
        localparam int  W      = IN_WIDTH + k;
        localparam int  N      = NUM_IN >> k;
        localparam bit  IS_REG = ((k % REG_STRIDE) == 0) || (k == LEVELS);

        logic [W-2:0] a [2*N];
        logic [W-1:0] s [N];
        logic [W-1:0] q [N];
        logic         v_in;
        logic         v_q;
`ifdef ADDER_TREE_ACC_EN
        logic         l_in;
        logic         l_q;
`endif

        if (k == 1) begin : src0
            for (genvar j = 0; j < 2*N; j++) begin : g
                assign a[j] = s0_data[j];
            end
            assign v_in = s0_valid;
`ifdef ADDER_TREE_ACC_EN
            assign l_in = s0_last;
`endif
        end else begin : srcn
            for (genvar j = 0; j < 2*N; j++) begin : g
                assign a[j] = lvl[k-1].q[j];
            end
            assign v_in = lvl[k-1].v_q;
`ifdef ADDER_TREE_ACC_EN
            assign l_in = lvl[k-1].l_q;
`endif
        end

        for (genvar j = 0; j < N; j++) begin : add
            if (SIGNED != 0) begin : sx
                assign s[j] = {a[2*j][W-2], a[2*j]} + {a[2*j+1][W-2], a[2*j+1]};
            end else begin : zx
                assign s[j] = {1'b0, a[2*j]} + {1'b0, a[2*j+1]};
            end
        end

        if (IS_REG) begin : r
            // Level register: loads only on a valid beat so the last sum is held.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    for (int i = 0; i < N; i++) begin
                        q[i] <= '0;
                    end
                end else begin
                    v_q <= v_in;
                    if (v_in) begin
                        for (int i = 0; i < N; i++) begin
                            q[i] <= s[i];
                        end
                    end
                end
            end
`ifdef ADDER_TREE_ACC_EN
            // Frame marker follows the valid bit through this register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    l_q <= 1'b0;
                end else begin
                    l_q <= l_in;
                end
            end
`endif
        end else begin : c
            assign v_q = v_in;
            for (genvar j = 0; j < N; j++) begin : g
                assign q[j] = s[j];
            end
`ifdef ADDER_TREE_ACC_EN
            assign l_q = l_in;
`endif
        end
    end

    logic                 out_valid_w;
    logic [SUM_WIDTH-1:0] out_sum_w;

    assign out_valid_w   = lvl[LEVELS].v_q;
    assign out_sum_w     = lvl[LEVELS].q[0];
    assign bus.out_valid = out_valid_w;
    assign bus.out_sum   = out_sum_w;

`ifdef ADDER_TREE_ACC_EN
    localparam int ACC_WIDTH = SUM_WIDTH + ACC_EXTRA;

    logic                 out_last_w;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_sum_q;
    logic [ACC_WIDTH-1:0] sum_ext;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 acc_valid_q;

    assign out_last_w = lvl[LEVELS].l_q;
    assign sum_ext    = (SIGNED != 0) ? ACC_WIDTH'($signed(out_sum_w))
                                      : ACC_WIDTH'(out_sum_w);
    assign acc_next   = acc + sum_ext;

    // Frame accumulator: wraps silently; the last beat publishes the total and restarts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            acc_sum_q   <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;
            if (out_valid_w) begin
                if (out_last_w) begin
                    acc_sum_q   <= acc_next;
                    acc_valid_q <= 1'b1;
                    acc         <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_sum   = acc_sum_q;
`endif
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: three 8x8-bit instances
// (unsigned stride 1, signed stride 1, unsigned stride 2) share one stimulus.
// Accumulator checks are compiled in when ADDER_TREE_ACC_EN is defined.
module tb_adder_tree_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    adder_tree_pipe_if #(.NUM_IN(8), .IN_WIDTH(8)) ifu ();
    adder_tree_pipe_if #(.NUM_IN(8), .IN_WIDTH(8)) ifs ();
    adder_tree_pipe_if #(.NUM_IN(8), .IN_WIDTH(8)) ifr ();

    adder_tree_pipe #(.NUM_IN(8), .IN_WIDTH(8), .REG_STRIDE(1), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .bus(ifu.slave));
    adder_tree_pipe #(.NUM_IN(8), .IN_WIDTH(8), .REG_STRIDE(1), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .bus(ifs.slave));
    adder_tree_pipe #(.NUM_IN(8), .IN_WIDTH(8), .REG_STRIDE(2), .SIGNED(0)) dut_r (
        .clk(clk), .rst(rst), .bus(ifr.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        ifu.in_valid = v; ifu.in_data = d;
        ifs.in_valid = v; ifs.in_data = d;
        ifr.in_valid = v; ifr.in_data = d;
    endtask

`ifdef ADDER_TREE_ACC_EN
    task automatic set_last(input logic l);
        ifu.in_last = l;
        ifs.in_last = l;
        ifr.in_last = l;
    endtask
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated beat; unsigned/signed stride-1 outputs 3 edges after accept, stride-2 after 2.
    task automatic run_beat(input string tag, input logic [63:0] d,
                            input logic [63:0] exp_u, input logic [63:0] exp_s);
        drive(1'b1, d);
        tick();
        drive(1'b0, 64'h0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk({tag, "_u_valid"}, 64'(ifu.out_valid), 64'(c == 3));
            chk({tag, "_s_valid"}, 64'(ifs.out_valid), 64'(c == 3));
            chk({tag, "_r_valid"}, 64'(ifr.out_valid), 64'(c == 2));
            if (c >= 3) begin
                chk({tag, "_u_sum"}, 64'(ifu.out_sum), exp_u);
                chk({tag, "_s_sum"}, 64'(ifs.out_sum), exp_s);
            end
            if (c >= 2) begin
                chk({tag, "_r_sum"}, 64'(ifr.out_sum), exp_u);
            end
        end
    endtask

    int kv [12] = '{1, 2, 3, 4, 5, 0, 0, 6, 7, 8, 9, 10};

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset with in_valid held high: nothing may be captured.
        rst = 1'b1;
        drive(1'b1, 64'h0101010101010101);
`ifdef ADDER_TREE_ACC_EN
        set_last(1'b0);
`endif
        tick(); tick(); tick();
        chk("rst_u_valid", 64'(ifu.out_valid), 64'h0);
        chk("rst_u_sum",   64'(ifu.out_sum),   64'h0);
        chk("rst_s_valid", 64'(ifs.out_valid), 64'h0);
        chk("rst_s_sum",   64'(ifs.out_sum),   64'h0);
        chk("rst_r_valid", 64'(ifr.out_valid), 64'h0);
        chk("rst_r_sum",   64'(ifr.out_sum),   64'h0);

        rst = 1'b0;
        drive(1'b0, 64'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_u_valid", 64'(ifu.out_valid), 64'h0);
            chk("idle_r_valid", 64'(ifr.out_valid), 64'h0);
        end

        run_beat("ones",  64'h0101010101010101, 64'h008, 64'h008);
        run_beat("max",   64'hFFFFFFFFFFFFFFFF, 64'h7F8, 64'h7F8);
        run_beat("alt",   64'h807F807F807F807F, 64'h3FC, 64'h7FC);
        run_beat("pos",   64'h8040201008040201, 64'h0FF, 64'h7FF);
        run_beat("ramp",  64'h0807060504030201, 64'h024, 64'h024);

        // Stream with a 2-cycle bubble: values and bubble pattern must reappear delayed.
        for (int j = 0; j < 15; j++) begin
            if (j < 12 && kv[j] != 0) drive(1'b1, 64'(kv[j]));
            else                      drive(1'b0, 64'h0);
            tick();
            if (j >= 3) begin
                chk("strm_u_valid", 64'(ifu.out_valid), 64'(kv[j-3] != 0));
                if (kv[j-3] != 0) chk("strm_u_sum", 64'(ifu.out_sum), 64'(kv[j-3]));
            end else begin
                chk("strm_u_valid", 64'(ifu.out_valid), 64'h0);
            end
            if (j >= 2 && j - 2 < 12) begin
                chk("strm_r_valid", 64'(ifr.out_valid), 64'(kv[j-2] != 0));
                if (kv[j-2] != 0) chk("strm_r_sum", 64'(ifr.out_sum), 64'(kv[j-2]));
            end
        end

        // Reset two cycles after accept: the beat must never emerge.
        drive(1'b1, 64'h0101010101010101);
        tick();
        drive(1'b0, 64'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_r_valid", 64'(ifr.out_valid), 64'h0);
        chk("midrst_r_sum",   64'(ifr.out_sum),   64'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("midrst_u_valid", 64'(ifu.out_valid), 64'h0);
            chk("midrst_u_sum",   64'(ifu.out_sum),   64'h0);
            chk("midrst_r_valid", 64'(ifr.out_valid), 64'h0);
            chk("midrst_r_sum",   64'(ifr.out_sum),   64'h0);
        end

        run_beat("post_rst", 64'h0202020202020202, 64'h010, 64'h010);

`ifdef ADDER_TREE_ACC_EN
        begin
            // Frames: {8,16,24,32}=80, {8}=8, {16,24}=40; acc pulse 4 edges after the last accept.
            logic [7:0] ab [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3};
            logic       al [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            chk("acc_rst_valid", 64'(ifu.acc_valid), 64'h0);
            for (int j = 0; j < 13; j++) begin
                if (j < 7) begin
                    drive(1'b1, {8{ab[j]}});
                    set_last(al[j]);
                end else begin
                    drive(1'b0, 64'h0);
                    set_last(1'b0);
                end
                tick();
                chk("acc_valid", 64'(ifu.acc_valid), 64'(j == 7 || j == 8 || j == 10));
                if (j == 7)  chk("acc_sum_f1", 64'(ifu.acc_sum), 64'd80);
                if (j == 8)  chk("acc_sum_f2", 64'(ifu.acc_sum), 64'd8);
                if (j == 10) chk("acc_sum_f3", 64'(ifu.acc_sum), 64'd40);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
